fir_deser8: RTL and testbench
=============================

Name: fir_deser8

Overview:
Upstream stage of the 8-parallel FIR. Accepts one signed 16-bit sample per cycle over a valid/ready stream and packs each 8 consecutive samples into one frame. Frames go out on the eight FIR input lanes x8k..x8k_7, with lane 0 holding the oldest sample. A one-frame pending buffer lets input run at 1 sample/cycle while the output is consumed, and absorbs up to one frame of output backpressure.

Parameters:
W, 16, sample width (two's complement), applies to din and all lanes
FCNT_W, 16, width of frame_cnt

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
din  in  W  serial input sample
in_valid  in  1  din valid
in_ready  out  1  block can accept din this cycle
flush  in  1  close current partial frame, zero-padding unused lanes
x8k, x8k_1, x8k_2, x8k_3, x8k_4, x8k_5, x8k_6, x8k_7  out  W each  frame lanes 0..7 (lane k = k-th accepted sample of frame)
out_valid  out  1  lanes hold a valid frame
out_ready  in  1  downstream consumes frame this cycle
frame_cnt  out  FCNT_W  number of frames handed off (out_valid&&out_ready), wraps modulo 2^FCNT_W

Behaviour:
- Accept = in_valid && in_ready. Handoff = out_valid && out_ready.
- Fill buffer: 8 x W regs plus a lane counter cnt (0..7). On accept, din is written to lane cnt and cnt increments.
- Two states:
  - FILL: in_ready=1.
  - PEND: fill buffer holds a complete frame waiting for the output register; in_ready=0.
- Frame completes on either:
  - an accept with cnt==7, or
  - flush=1 with the resulting lane count >0 (including a sample accepted in the same cycle). Lanes at and above that count are zeroed.
- On completion, cnt returns to 0.
- Transfer rule on completion edge:
  - If the output register is free (out_valid==0 or handoff this cycle), the frame loads into x8k..x8k_7 and out_valid=1 from the next cycle.
  - Otherwise the state goes to PEND.
- In PEND, on a handoff edge the fill buffer moves to the output register, out_valid stays 1, and the state returns to FILL.
- Latency: 8th sample accepted at edge N gives the frame visible after edge N when the output slot is free. No combinational path din->lanes.
- Handoff with no new frame ready: out_valid=0 next cycle. Lanes keep their last values (don't-care while out_valid=0).
- Flush cases:
  - flush with cnt==0 and no accept: no effect.
  - flush in PEND: ignored (in_ready=0, no partial frame exists).
- Arithmetic:
  - Samples are passed bit-exact, no scaling or saturation.
  - frame_cnt increments by 1 per handoff and wraps to 0 after all-ones.
- Reset (rst=1 at an edge): state FILL, cnt=0, out_valid=0, all lanes=0, frame_cnt=0, fill buffer cleared.
  - in_ready=0 while rst is high; it becomes 1 the first cycle after rst deasserts.
  - A partial or pending frame is discarded on reset.
- Simultaneous events:
  - Completion and handoff on the same edge: the new frame replaces the old with no bubble.
  - flush and a 7th-lane accept together: normal full frame (no zeros).
- Throughput: with out_ready held 1, in_ready never deasserts; sustained 1 sample/cycle.

Test Plan:
1. Reset, then din=1..8 on 8 consecutive cycles, out_ready=1 -> cycle after 8th accept: out_valid=1, x8k..x8k_7=1,2,3,4,5,6,7,8; frame_cnt=1 after the handoff edge.
2. out_ready=0, stream 20 samples with in_valid=1 -> frame 1 on lanes; frame 2 completes and enters PEND; in_ready drops after the 16th accept; samples 17-20 stall. Raise out_ready -> frame 2 (9..16) appears next cycle, in_ready=1, samples 17-20 accepted.
3. Samples 5,-6,7, then flush=1 alone -> lanes 5,-6,7,0,0,0,0,0, out_valid=1; a following flush with cnt==0 produces no frame.
4. Continuous 64-sample ramp with out_ready=1 -> in_ready constantly 1, 8 frames in order, lane k of frame f = 8f+k, frame_cnt=8.
5. Accept 5 samples, assert rst one cycle mid-frame -> all lanes 0, out_valid=0, frame_cnt=0. The next 8 samples (-32768, 32767, ...) form a fresh frame with no leftover data, extremes passed bit-exact.
6. Frame completion coinciding with a handoff edge (out_ready=1 at the 8th accept of frame 2) -> out_valid stays 1 and lanes switch from frame 1 to frame 2 on that edge with no bubble.

Source files
------------

// File: rtl/fir_deser8.sv
// fir_deser8: serial-to-parallel front end for the 8-parallel FIR.
// Packs 8 consecutive signed samples into one frame. Lane 0 holds the oldest
// sample. A single pending frame buffer sustains 1 sample/cycle and absorbs
// one frame of output backpressure.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   din, in_valid        serial sample stream
//   in_ready             sample accepted when in_valid && in_ready
//   flush                close the current partial frame, zero-padding lanes
//   x8k .. x8k_7         frame lanes 0..7
//   out_valid, out_ready frame handshake
//   frame_cnt            number of frames handed off, wraps
module fir_deser8 #(
    parameter int W      = 16,
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W-1:0]      din,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [W-1:0]      x8k,
    output logic [W-1:0]      x8k_1,
    output logic [W-1:0]      x8k_2,
    output logic [W-1:0]      x8k_3,
    output logic [W-1:0]      x8k_4,
    output logic [W-1:0]      x8k_5,
    output logic [W-1:0]      x8k_6,
    output logic [W-1:0]      x8k_7,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FCNT_W-1:0] frame_cnt
);

    typedef enum logic {FILL, PEND} state_t;

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] fill_buf [8];
    logic [W-1:0] lane     [8];
    logic [W-1:0] frame    [8];
    logic [2:0]   cnt;
    logic [3:0]   cnt_acc;
    logic         accept;
    logic         handoff;
    logic         out_free;
    logic         complete;
    logic         valid_q;

    // Handshake decode and the frame that would complete on this edge.
    // The completed frame merges stored lanes, the sample accepted this
    // cycle, and zero padding above the resulting lane count.
    always_comb begin
        accept   = in_valid && in_ready;
        handoff  = valid_q && out_ready;
        out_free = !valid_q || out_ready;
        cnt_acc  = {1'b0, cnt} + {3'b000, accept};
        complete = (state == FILL) &&
                   ((accept && cnt == 3'd7) || (flush && cnt_acc != 4'd0));
        for (int unsigned i = 0; i < 8; i++) begin
            if (3'(i) < cnt)
                frame[i] = fill_buf[i];
            else if (3'(i) == cnt && accept)
                frame[i] = din;
            else
                frame[i] = '0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= FILL;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: if (complete && !out_free) state_nxt = PEND;
            PEND: if (handoff)               state_nxt = FILL;
            default:                         state_nxt = FILL;
        endcase
    end

    // State outputs; held low during reset so nothing is taken while clearing.
    always_comb begin
        in_ready = (state == FILL) && !rst;
    end

    // Datapath: fill buffer, output lanes, frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            valid_q   <= 1'b0;
            frame_cnt <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                fill_buf[i] <= '0;
                lane[i]     <= '0;
            end
        end else begin
            if (complete) begin
                cnt <= '0;
                // Output slot busy: park the whole completed frame in the
                // fill buffer, which then acts as the pending slot.
                if (!out_free)
                    fill_buf <= frame;
            end else if (accept) begin
                fill_buf[cnt] <= din;
                cnt           <= cnt + 3'd1;
            end

            if (complete && out_free) begin
                lane    <= frame;
                valid_q <= 1'b1;
            end else if (state == PEND && handoff) begin
                lane    <= fill_buf;
                valid_q <= 1'b1;
            end else if (handoff) begin
                valid_q <= 1'b0;
            end

            if (handoff)
                frame_cnt <= frame_cnt + FCNT_W'(1);
        end
    end

    assign x8k       = lane[0];
    assign x8k_1     = lane[1];
    assign x8k_2     = lane[2];
    assign x8k_3     = lane[3];
    assign x8k_4     = lane[4];
    assign x8k_5     = lane[5];
    assign x8k_6     = lane[6];
    assign x8k_7     = lane[7];
    assign out_valid = valid_q;

endmodule

// File: tb/tb_fir_deser8.sv
// tb_fir_deser8: self-checking bench for fir_deser8.
// Reference model: a queue of completed frames (front = output register,
// at most one more waiting) and a queue of samples in the partial frame.
module tb_fir_deser8;

    localparam int W  = 16;
    localparam int FC = 4;   // narrow counter so wraparound is exercised

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  din;
    logic          in_valid;
    logic          in_ready;
    logic          flush;
    logic [W-1:0]  x8k, x8k_1, x8k_2, x8k_3, x8k_4, x8k_5, x8k_6, x8k_7;
    logic          out_valid;
    logic          out_ready;
    logic [FC-1:0] frame_cnt;

    always #5 clk = ~clk;

    fir_deser8 #(.W(W), .FCNT_W(FC)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .x8k       (x8k),
        .x8k_1     (x8k_1),
        .x8k_2     (x8k_2),
        .x8k_3     (x8k_3),
        .x8k_4     (x8k_4),
        .x8k_5     (x8k_5),
        .x8k_6     (x8k_6),
        .x8k_7     (x8k_7),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_cnt (frame_cnt)
    );

    logic [W-1:0] lanes [8];
    assign lanes[0] = x8k;
    assign lanes[1] = x8k_1;
    assign lanes[2] = x8k_2;
    assign lanes[3] = x8k_3;
    assign lanes[4] = x8k_4;
    assign lanes[5] = x8k_5;
    assign lanes[6] = x8k_6;
    assign lanes[7] = x8k_7;

    int total = 0;
    int bad   = 0;

    logic [8*W-1:0] fq [$];          // completed frames, front is on the lanes
    logic [W-1:0]   part [$];        // samples of the open frame
    logic [8*W-1:0] shown = '0;      // frame currently driven on the lanes
    logic [FC-1:0]  fcnt  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_ready();
        return !rst && fq.size() < 2;
    endfunction

    // Compare DUT against model mid-cycle, then advance the model by one edge.
    task automatic cycle(output bit acc);
        bit             hand;
        logic [8*W-1:0] f;
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'(m_ready()));
        check("out_valid", 32'(out_valid), 32'(fq.size() > 0));
        check("frame_cnt", 32'(frame_cnt), 32'(fcnt));
        for (int k = 0; k < 8; k++)
            check($sformatf("lane%0d", k), 32'(lanes[k]), 32'(shown[k*W +: W]));
        acc = 1'b0;
        if (rst) begin
            fq.delete();
            part.delete();
            shown = '0;
            fcnt  = '0;
        end else begin
            acc  = in_valid && m_ready();
            hand = fq.size() > 0 && out_ready;
            if (acc) part.push_back(din);
            if (hand) begin
                void'(fq.pop_front());
                fcnt = fcnt + 1'b1;
            end
            if (part.size() == 8 || (flush && part.size() > 0)) begin
                f = '0;
                for (int k = 0; k < part.size(); k++) f[k*W +: W] = part[k];
                fq.push_back(f);
                part.delete();
            end
            if (fq.size() > 0) shown = fq[0];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic v, input logic [W-1:0] d, input logic fl,
                        input logic ordy, output bit acc);
        rst = 1'b0; in_valid = v; din = d; flush = fl; out_ready = ordy;
        cycle(acc);
    endtask

    task automatic do_reset(input int n);
        bit a;
        for (int i = 0; i < n; i++) begin
            rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; din = '0;
            cycle(a);
        end
    endtask

    initial begin
        bit acc;
        int idx;
        int guard;
        rst = 1'b1; in_valid = 1'b0; din = '0; flush = 1'b0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        do_reset(2);

        // 1: 1..8 with out_ready high
        for (int s = 1; s <= 8; s++) tick(1'b1, W'(s), 1'b0, 1'b1, acc);
        for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b0, 1'b1, acc);

        // 2: backpressure, 20 samples held until taken
        do_reset(1);
        idx = 1;
        for (int i = 0; i < 24; i++) begin
            tick(idx <= 20, W'(idx), 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        check("stall_idx", 32'(idx), 32'd17);
        guard = 0;
        while (idx <= 20 && guard < 50) begin
            tick(1'b1, W'(idx), 1'b0, 1'b1, acc);
            if (acc) idx++;
            guard++;
        end
        check("stall_release", 32'(idx), 32'd21);
        for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b0, 1'b1, acc);

        // 3: partial frame via flush, then a no-op flush
        do_reset(1);
        tick(1'b1, W'(5), 1'b0, 1'b0, acc);
        tick(1'b1, W'(-6), 1'b0, 1'b0, acc);
        tick(1'b1, W'(7), 1'b0, 1'b0, acc);
        tick(1'b0, '0, 1'b1, 1'b0, acc);
        tick(1'b0, '0, 1'b0, 1'b1, acc);
        tick(1'b0, '0, 1'b1, 1'b1, acc);
        tick(1'b0, '0, 1'b0, 1'b1, acc);
        // flush together with the 8th sample
        for (int s = 0; s < 8; s++) tick(1'b1, W'(100 + s), s == 7, 1'b1, acc);
        tick(1'b0, '0, 1'b0, 1'b1, acc);

        // 4/6: continuous ramp, back-to-back frames with no bubble
        do_reset(1);
        for (int s = 0; s < 64; s++) tick(1'b1, W'(s), 1'b0, 1'b1, acc);
        for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b0, 1'b1, acc);

        // 5: reset mid-frame, then extreme values
        for (int s = 0; s < 5; s++) tick(1'b1, W'(s + 40), 1'b0, 1'b0, acc);
        do_reset(1);
        tick(1'b1, 16'h8000, 1'b0, 1'b0, acc);
        tick(1'b1, 16'h7fff, 1'b0, 1'b0, acc);
        tick(1'b1, 16'hffff, 1'b0, 1'b0, acc);
        tick(1'b1, 16'h0001, 1'b0, 1'b0, acc);
        tick(1'b1, 16'h8001, 1'b0, 1'b0, acc);
        tick(1'b1, 16'h7ffe, 1'b0, 1'b0, acc);
        tick(1'b1, 16'h0000, 1'b0, 1'b0, acc);
        tick(1'b1, 16'haaaa, 1'b0, 1'b0, acc);
        tick(1'b0, '0, 1'b0, 1'b1, acc);
        tick(1'b0, '0, 1'b0, 1'b1, acc);

        // Random traffic, including occasional flush and reset
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset(1);
            end else begin
                tick($urandom_range(0, 3) != 0, W'($urandom),
                     $urandom_range(0, 9) == 0, $urandom_range(0, 4) < 3, acc);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
